fft32_sdf_sequencer: RTL and testbench

- Global sequencer for the 32-point radix-2 single-path delay-feedback (SDF) FFT pipeline: five butterfly stages, stage k holding a 16>>k deep feedback shift register.
- Owns a master sample counter and derives, per stage, the butterfly/fill mux select and the 4-bit twiddle index into the shared W32 table.
- Also generates the global pipeline enable, input-ready, stream drain (flush) and output-valid/frame markers.
- Sits between the input stream and the five stage datapaths; the stages hold no counters of their own.

---
 rtl/fft32_sdf_sequencer_pkg.sv | 25 ++
 rtl/fft32_sdf_sequencer_stage_ctl.sv | 25 ++
 rtl/fft32_sdf_sequencer.sv | 101 ++++++++++
 tb/tb_fft32_sdf_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fft32_sdf_sequencer_pkg.sv
// fft_ctrl_pkg: shared constants, state type and helpers for the 32-point SDF FFT sequencer
//   H_K     : feedback shift-register depth of each stage (16 >> k)
//   l_of    : control offset L_k of stage k (depth plus pipe registers of all earlier stages)
//   lat_of  : input-to-output latency, equal to the offset just past the last stage
//   bitrev5 : 5-bit bit reversal, maps DIF output order to frequency bin
package fft_ctrl_pkg;
    localparam int N = 32;
    localparam int LOG2N = 5;
    localparam int STAGES = 5;
    localparam int H_K [STAGES] = '{16, 8, 4, 2, 1};
    typedef logic [LOG2N-1:0] cnt_t;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} seq_state_e;
    function automatic int l_of(input int k, input int stage_pipe);
        int s;
        s = 0;
        for (int j = 0; j < k; j++) s = s + ((N / 2) >> j) + stage_pipe;
        return s;
    endfunction
    function automatic int lat_of(input int stage_pipe);
        return l_of(STAGES, stage_pipe);
    endfunction
    function automatic cnt_t bitrev5(input cnt_t x);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction
endpackage

// File: rtl/fft32_sdf_sequencer_stage_ctl.sv
// fft_stage_ctl_gen: per-stage mode select and twiddle index derived from the master count
//   t   : master sample count
//   sel : 0 fill/feedback, 1 butterfly
//   tw  : twiddle index into the shared W32 table (0 while in butterfly mode)
module fft_stage_ctl_gen
    import fft_ctrl_pkg::*;
#(
    parameter int K = 0,
    parameter int STAGE_PIPE = 1
) (
    input  cnt_t       t,
    output logic       sel,
    output logic [3:0] tw
);
    localparam cnt_t L = cnt_t'(l_of(K, STAGE_PIPE));
    localparam cnt_t MASK = cnt_t'(H_K[K] - 1);
    cnt_t m;
    // The local index lags the master count by the delay of all upstream stages;
    // the twiddle exponent scales by 2^K because stage K sees an N>>K point sub-FFT.
    always_comb begin
        m = t - L;
        sel = m[LOG2N-1-K];
        tw = sel ? 4'd0 : 4'((m & MASK) << K);
    end
endmodule

// File: rtl/fft32_sdf_sequencer.sv
// fft32_sdf_sequencer: global sequencer for the five-stage radix-2 SDF 32-point FFT
//   clk, rst       : clock, synchronous active-high reset
//   valid_i/last_i : input sample present / final sample of stream
//   ready_o, en_o  : input accepted / global pipeline enable
//   zero_in_o      : datapath input forced to zero while draining
//   sel_o, tw_o    : per-stage butterfly select and 4-bit twiddle index (stage k at [4k+3:4k])
//   valid_o, frame_start_o, out_idx_o : registered output valid, frame marker, output index
//   busy_o, frame_err_o : not idle / sticky short-frame flag
//   FFT_SEQ_BITREV_EN : when defined, out_idx_o carries the bit-reversed (true bin) index
module fft32_sdf_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int STAGE_PIPE = 1,
    parameter bit FLUSH_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        last_i,
    output logic        ready_o,
    output logic        en_o,
    output logic        zero_in_o,
    output logic [4:0]  sel_o,
    output logic [19:0] tw_o,
    output logic        valid_o,
    output logic        frame_start_o,
    output logic [4:0]  out_idx_o,
    output logic        busy_o,
    output logic        frame_err_o
);
    localparam int LAT = lat_of(STAGE_PIPE);
    localparam logic [5:0] LAT6 = 6'(LAT);
    seq_state_e state;
    cnt_t t;
    logic [5:0] oc;
    logic [5:0] fc;
    logic take_last;
    logic out_full;
    cnt_t out_cnt;
    cnt_t idx_nxt;
    always_comb begin
        ready_o = state != FLUSH;
        en_o = (state == FLUSH) || valid_i;
        zero_in_o = (state == FLUSH) && FLUSH_ZERO;
        busy_o = state != IDLE;
        take_last = ready_o && valid_i && last_i;
        out_full = en_o && (oc >= LAT6);
        out_cnt = t - cnt_t'(LAT);
`ifdef FFT_SEQ_BITREV_EN
        idx_nxt = bitrev5(out_cnt);
`else
        idx_nxt = out_cnt;
`endif
    end
    // oc only needs to reach LAT, so it saturates instead of wrapping; fc times the drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            t <= '0;
            oc <= '0;
            fc <= '0;
            frame_err_o <= 1'b0;
            valid_o <= 1'b0;
            frame_start_o <= 1'b0;
            out_idx_o <= '0;
        end else begin
            valid_o <= out_full;
            frame_start_o <= out_full && (out_cnt == '0);
            out_idx_o <= idx_nxt;
            if (take_last && t != cnt_t'(N - 1)) frame_err_o <= 1'b1;
            if (en_o) begin
                t <= t + cnt_t'(1);
                oc <= (oc == LAT6) ? oc : oc + 6'd1;
            end
            if (state == FLUSH) begin
                fc <= fc + 6'd1;
                if (fc == LAT6 - 6'd1) begin
                    state <= IDLE;
                    t <= '0;
                    oc <= '0;
                    fc <= '0;
                end
            end else if (take_last) begin
                state <= FLUSH;
                fc <= '0;
            end else if (valid_i) begin
                state <= RUN;
            end
        end
    end
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        fft_stage_ctl_gen #(
            .K(k),
            .STAGE_PIPE(STAGE_PIPE)
        ) u_stage (
            .t(t),
            .sel(sel_o[k]),
            .tw(tw_o[4*k +: 4])
        );
    end
endmodule

// File: tb/tb_fft32_sdf_sequencer.sv
// tb_fft32_sdf_sequencer: directed self-checking bench for the SDF FFT sequencer
module tb_fft32_sdf_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        last_i;
    logic        ready_o;
    logic        en_o;
    logic        zero_in_o;
    logic [4:0]  sel_o;
    logic [19:0] tw_o;
    logic        valid_o;
    logic        frame_start_o;
    logic [4:0]  out_idx_o;
    logic        busy_o;
    logic        frame_err_o;
    fft32_sdf_sequencer dut (
        .clk(clk),
        .rst(rst),
        .valid_i(valid_i),
        .last_i(last_i),
        .ready_o(ready_o),
        .en_o(en_o),
        .zero_in_o(zero_in_o),
        .sel_o(sel_o),
        .tw_o(tw_o),
        .valid_o(valid_o),
        .frame_start_o(frame_start_o),
        .out_idx_o(out_idx_o),
        .busy_o(busy_o),
        .frame_err_o(frame_err_o)
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int vcnt = 0;
    int fcnt = 0;
    int vcyc [0:1023];
    int vidx [0:1023];
    int fpos [0:63];
    always @(negedge clk) begin
        if (valid_o) begin
            vcyc[vcnt] <= cyc;
            vidx[vcnt] <= int'(out_idx_o);
            vcnt <= vcnt + 1;
        end
        if (frame_start_o) begin
            fpos[fcnt] <= vcnt;
            fcnt <= fcnt + 1;
        end
    end
    int n_chk = 0;
    int n_pass = 0;
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask
    task automatic step(input logic v, input logic l);
        @(posedge clk);
        #1;
        valid_i = v;
        last_i = l;
        #1;
    endtask
    function automatic int eidx(input int i);
`ifdef FFT_SEQ_BITREV_EN
        int r;
        r = 0;
        for (int b = 0; b < 5; b++) if ((i & (1 << b)) != 0) r = r | (1 << (4 - b));
        return r;
`else
        return i;
`endif
    endfunction
    int b;
    int fb;
    int c0;
    initial begin
        rst = 1'b1;
        valid_i = 1'b0;
        last_i = 1'b0;
        repeat (3) step(0, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_fstart", frame_start_o, 0);
        chk("rst_err", frame_err_o, 0);
        chk("rst_idx", out_idx_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_sel", sel_o, 5'b00110);
        chk("rst_tw", tw_o, 20'h08000);
        rst = 1'b0;
        // single frame
        b = vcnt;
        fb = fcnt;
        for (int c = 0; c < 32; c++) begin
            step(1, c == 31);
            if (c == 0) c0 = cyc;
            chk("f1_sel0", sel_o[0], c >= 16 ? 1 : 0);
            chk("f1_tw0", tw_o[3:0], c < 16 ? c : 0);
            chk("f1_sel1", sel_o[1], (((c + 15) & 31) >> 3) & 1);
            chk("f1_tw1", tw_o[7:4], ((((c + 15) & 31) >> 3) & 1) == 1 ? 0 : (((c + 15) & 7) << 1));
            chk("f1_en", en_o, 1);
        end
        for (int i = 0; i < 36; i++) begin
            step(0, 0);
            chk("f1_fl_ready", ready_o, 0);
            chk("f1_fl_en", en_o, 1);
            chk("f1_fl_zero", zero_in_o, 1);
        end
        step(0, 0);
        chk("f1_idle", busy_o, 0);
        chk("f1_idle_ready", ready_o, 1);
        repeat (2) step(0, 0);
        chk("f1_nvalid", vcnt - b, 32);
        chk("f1_nfs", fcnt - fb, 1);
        chk("f1_first", vcyc[b] - c0, 37);
        chk("f1_fspos", fpos[fb] - b, 0);
        chk("f1_err", frame_err_o, 0);
        for (int i = 0; i < 32; i++) chk("f1_idx", vidx[b + i], eidx(i));
        // three frames back to back, valid_i held in the flush-exit cycle
        b = vcnt;
        fb = fcnt;
        for (int c = 0; c < 96; c++) begin
            step(1, c == 95);
            if (c == 0) c0 = cyc;
        end
        for (int i = 0; i < 36; i++) begin
            step(i == 35, 0);
            if (i == 35) chk("f3_exit_ready", ready_o, 0);
        end
        step(0, 0);
        chk("f3_idle", busy_o, 0);
        repeat (2) step(0, 0);
        chk("f3_nvalid", vcnt - b, 96);
        chk("f3_first", vcyc[b] - c0, 37);
        chk("f3_contig", vcyc[b + 95] - vcyc[b], 95);
        chk("f3_nfs", fcnt - fb, 3);
        chk("f3_fs0", fpos[fb] - b, 0);
        chk("f3_fs1", fpos[fb + 1] - b, 32);
        chk("f3_fs2", fpos[fb + 2] - b, 64);
        chk("f3_idx40", vidx[b + 40], eidx(8));
        // two frames, 5-cycle stall at t=10 of the second frame
        b = vcnt;
        fb = fcnt;
        for (int c = 0; c < 64; c++) begin
            if (c == 42) begin
                for (int s = 0; s < 5; s++) begin
                    step(0, 0);
                    chk("st_en", en_o, 0);
                    chk("st_tw0", tw_o[3:0], 10);
                    chk("st_ready", ready_o, 1);
                end
            end
            step(1, c == 63);
            if (c == 0) c0 = cyc;
        end
        repeat (36) step(0, 0);
        repeat (3) step(0, 0);
        chk("st_nvalid", vcnt - b, 64);
        chk("st_first", vcyc[b] - c0, 37);
        chk("st_gap", vcyc[b + 6] - vcyc[b + 5], 6);
        chk("st_contig", vcyc[b + 63] - vcyc[b + 6], 57);
        chk("st_idx6", vidx[b + 6], eidx(6));
        chk("st_nfs", fcnt - fb, 2);
        chk("st_err", frame_err_o, 0);
        // short frame: last_i at t=20
        b = vcnt;
        for (int c = 0; c < 21; c++) step(1, c == 20);
        for (int i = 0; i < 36; i++) begin
            step(0, 0);
            if (i == 0) chk("se_err", frame_err_o, 1);
            chk("se_busy", busy_o, 1);
            chk("se_zero", zero_in_o, 1);
        end
        step(0, 0);
        chk("se_idle", busy_o, 0);
        repeat (2) step(0, 0);
        chk("se_sticky", frame_err_o, 1);
        chk("se_nvalid", vcnt - b, 21);
        // reset while draining
        for (int c = 0; c < 4; c++) step(1, c == 3);
        repeat (5) step(0, 0);
        chk("rf_busy_pre", busy_o, 1);
        rst = 1'b1;
        step(0, 0);
        rst = 1'b0;
        chk("rf_busy", busy_o, 0);
        chk("rf_valid", valid_o, 0);
        chk("rf_err", frame_err_o, 0);
        chk("rf_sel", sel_o, 5'b00110);
        chk("rf_tw", tw_o, 20'h08000);
        b = vcnt;
        repeat (40) step(0, 0);
        chk("rf_nodrain", vcnt - b, 0);
        chk("rf_idle", busy_o, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
